// File: rtl/frame_tick_ctrl_pkg.sv
// Shared definitions for the frame tick scheduler: FSM state encoding,
// the default input clock frequency, and the rate range check.
package frame_tick_ctrl_pkg;

  localparam int unsigned IN_FREQ_DEFAULT = 100_000_000;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  function automatic logic rate_legal(input logic [63:0] rate, input logic [63:0] in_freq);
    return (rate != 64'd0) && (rate <= in_freq);
  endfunction

endpackage

// File: rtl/frame_tick_ctrl_accum.sv
// Signed phase accumulator: adds rate each enabled cycle and subtracts
// IN_FREQ whenever it is non-negative, emitting a registered tick.
module frac_accum #(
  parameter int unsigned IN_FREQ = 100_000_000,
  parameter int unsigned RATE_W  = 32,
  parameter int unsigned ACC_W   = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              tick_o,
  output logic              msb_o
);

  localparam logic [ACC_W-1:0] FREQ_EXT = ACC_W'(IN_FREQ);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q;
  logic             tick_cond;

  // Two's complement: MSB clear means the phase has crossed zero.
  assign tick_cond = enable_i & ~acc_q[ACC_W-1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_d = acc_q + ACC_W'(rate_i) - (tick_cond ? FREQ_EXT : '0);
    if (clear_i) acc_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_cond;
    end
  end

  assign tick_o = tick_q;
  assign msb_o  = acc_q[ACC_W-1];

endmodule

// File: rtl/frame_tick_ctrl.sv
// Programmable fractional frame tick generator with start/stop sequencing,
// tick-boundary rate updates via a valid/ready port, and a frame counter.
module frame_tick_ctrl
  import frame_tick_ctrl_pkg::*;
#(
  parameter int unsigned IN_FREQ      = IN_FREQ_DEFAULT,
  parameter int unsigned DEFAULT_RATE = 60,
  parameter int unsigned RATE_W       = 32,
  parameter int unsigned ACC_W        = 40,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_valid,
  input  logic [RATE_W-1:0] cfg_rate,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              tick,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              running,
  output logic [RATE_W-1:0] rate_q
);

  state_e            state_q;
  logic              running_q;
  logic              pending_q;
  logic              cfg_err_q;
  logic [RATE_W-1:0] rate_reg_q;
  logic [RATE_W-1:0] shadow_q;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic acc_msb;
  logic active;
  logic tick_cond;
  logic stop_done;
  logic xfer;
  logic legal;
  logic acc_clear;

  assign active    = (state_q != ST_OFF);
  assign tick_cond = active & ~acc_msb;
  // A start in STOPPING cancels the stop even on a tick edge.
  assign stop_done = (state_q == ST_STOPPING) & ~start & tick_cond;
  assign acc_clear = ~active | stop_done;

  assign cfg_ready = ~pending_q;
  assign xfer      = cfg_valid & cfg_ready;
  assign legal     = rate_legal(64'(cfg_rate), 64'(IN_FREQ));

  frac_accum #(
    .IN_FREQ (IN_FREQ),
    .RATE_W  (RATE_W),
    .ACC_W   (ACC_W)
  ) u_accum (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (acc_clear),
    .enable_i (active),
    .rate_i   (rate_reg_q),
    .tick_o   (tick),
    .msb_o    (acc_msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_OFF;
      running_q   <= 1'b0;
      pending_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      rate_reg_q  <= RATE_W'(DEFAULT_RATE);
      shadow_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      cfg_err_q <= xfer & ~legal;

      case (state_q)
        ST_OFF: begin
          if (start) begin
            state_q     <= ST_RUN;
            running_q   <= 1'b1;
            frame_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (stop && !start) state_q <= ST_STOPPING;
        end
        ST_STOPPING: begin
          if (start) begin
            state_q <= ST_RUN;
          end else if (tick_cond) begin
            state_q   <= ST_OFF;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_OFF;
          running_q <= 1'b0;
        end
      endcase

      if (tick_cond) frame_cnt_q <= frame_cnt_q + CNT_W'(1);

      // A transfer needs pending clear, so it never collides with the shadow apply.
      if (xfer && legal) begin
        if (!active) begin
          rate_reg_q <= cfg_rate;
        end else begin
          shadow_q  <= cfg_rate;
          pending_q <= 1'b1;
        end
      end

      if (pending_q && tick_cond) begin
        rate_reg_q <= shadow_q;
        pending_q  <= 1'b0;
      end
    end
  end

  assign cfg_err   = cfg_err_q;
  assign frame_cnt = frame_cnt_q;
  assign running   = running_q;
  assign rate_q    = rate_reg_q;

endmodule

// File: tb/tb_frame_tick_ctrl.sv
// Directed bench for frame_tick_ctrl: cadence, live rate update, bad config,
// stop/start sequencing and reset abort, with hand-computed expectations.
module tb_frame_tick_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_rate = '0;

  logic        cfg_ready, cfg_err, tick, running;
  logic [15:0] frame_cnt;
  logic [31:0] rate_q;

  logic        cfg_valid2 = 1'b0;
  logic [31:0] cfg_rate2 = '0;
  logic        cfg_ready2, cfg_err2, tick2, running2;
  logic [15:0] frame_cnt2;
  logic [31:0] rate_q2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_tick_ctrl #(
    .IN_FREQ(10), .DEFAULT_RATE(7), .RATE_W(32), .ACC_W(40), .CNT_W(16)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_rate(cfg_rate), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .tick(tick), .frame_cnt(frame_cnt),
    .running(running), .rate_q(rate_q)
  );

  frame_tick_ctrl #(
    .IN_FREQ(100), .DEFAULT_RATE(10), .RATE_W(32), .ACC_W(40), .CNT_W(16)
  ) u_dut100 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_valid(cfg_valid2), .cfg_rate(cfg_rate2), .cfg_ready(cfg_ready2),
    .cfg_err(cfg_err2), .tick(tick2), .frame_cnt(frame_cnt2),
    .running(running2), .rate_q(rate_q2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] frac_pat;
    logic [6:0] upd_pat;
    frac_pat = 10'b1001001000;
    upd_pat  = 7'b1010100;

    // Reset state
    cyc(2);
    check("rst_tick", tick, 0);
    check("rst_err", cfg_err, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_run", running, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_rate", rate_q, 7);
    check("rst_rate100", rate_q2, 10);
    reset = 1'b0;
    cyc();

    // Out-of-range config in OFF
    cfg_valid = 1'b1; cfg_rate = 0;
    cyc();
    check("bad0_err", cfg_err, 1);
    check("bad0_rate", rate_q, 7);
    check("bad0_ready", cfg_ready, 1);
    cfg_rate = 11;
    cyc();
    check("bad11_err", cfg_err, 1);
    check("bad11_rate", rate_q, 7);
    cfg_valid = 1'b0;
    cyc();
    check("err_pulse_end", cfg_err, 0);

    // Legal config in OFF loads directly
    cfg_valid = 1'b1; cfg_rate = 3;
    cyc();
    cfg_valid = 1'b0;
    check("off_load_rate", rate_q, 3);
    check("off_load_ready", cfg_ready, 1);
    check("off_load_err", cfg_err, 0);

    // Fractional cadence rate=3/10, plus integer cadence 10/100
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_run", running, 1);
    check("start_tick", tick, 0);
    cyc();
    check("first_tick", tick, 1);
    check("first_cnt", frame_cnt, 1);
    check("first_tick100", tick2, 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("frac_tick_%0d", i), tick, frac_pat[i]);
    end
    check("frac_cnt4", frame_cnt, 4);
    check("int_tick100", tick2, 1);
    check("int_cnt100_2", frame_cnt2, 2);
    cyc(100);
    check("frac_cnt34", frame_cnt, 34);
    check("int_cnt100_12", frame_cnt2, 12);

    // Stop mid-interval: final tick emitted and counted
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stopping_run", running, 1);
    check("stopping_tick", tick, 0);
    cyc(2);
    check("stopping_hold", running, 1);
    cyc();
    check("final_tick", tick, 1);
    check("final_cnt", frame_cnt, 35);
    check("final_off", running, 0);
    cyc();
    check("off_tick", tick, 0);
    check("off_cnt", frame_cnt, 35);

    // Start during STOPPING cancels the stop with no extra tick
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_cnt", frame_cnt, 0);
    cyc();
    check("restart_tick", tick, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    check("cancel_run", running, 1);
    check("cancel_tick", tick, 0);
    cyc();
    check("cancel_tick2", tick, 0);
    cyc();
    check("cancel_next_tick", tick, 1);
    check("cancel_cnt", frame_cnt, 2);
    check("cancel_still_run", running, 1);
    cyc();

    // start & stop together in RUN stays RUN; accept a rate on the tick edge
    start = 1'b1; stop = 1'b1;
    cyc();
    check("both_run", running, 1);
    cfg_valid = 1'b1; cfg_rate = 5;
    cyc();
    check("both_tick", tick, 1);
    check("both_cnt", frame_cnt, 3);
    check("both_still_run", running, 1);
    check("pend_ready", cfg_ready, 0);
    check("pend_rate_old", rate_q, 3);

    // Reset mid-run aborts immediately
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_tick", tick, 0);
    check("midrst_run", running, 0);
    check("midrst_ready", cfg_ready, 1);
    check("midrst_rate", rate_q, 7);
    check("midrst_cnt", frame_cnt, 0);
    check("midrst_run100", running2, 0);
    cyc();
    check("midrst_hold_tick", tick, 0);
    reset = 1'b0;
    cyc();

    // Live update: rate 2 running, offer 5 mid-interval
    cfg_valid = 1'b1; cfg_rate = 2;
    cyc();
    cfg_valid = 1'b0;
    check("live_load2", rate_q, 2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(3);
    cfg_valid = 1'b1; cfg_rate = 5;
    cyc();
    cfg_rate = 7;
    check("live_ready_low", cfg_ready, 0);
    check("live_rate_old", rate_q, 2);
    cyc();
    check("live_no_tick", tick, 0);
    check("live_ready_low2", cfg_ready, 0);
    check("live_rate_old2", rate_q, 2);
    cyc();
    check("live_tick", tick, 1);
    check("live_rate_new", rate_q, 5);
    check("live_ready_high", cfg_ready, 1);
    check("live_cnt", frame_cnt, 2);
    cfg_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check($sformatf("live_tick_%0d", i), tick, upd_pat[i]);
    end
    check("live_held_off", rate_q, 5);
    check("live_cnt5", frame_cnt, 5);

    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop2_run", running, 1);
    cyc();
    check("stop2_tick", tick, 1);
    check("stop2_off", running, 0);
    check("stop2_cnt", frame_cnt, 6);

    // rate == IN_FREQ: tick every cycle
    cfg_valid = 1'b1; cfg_rate = 10;
    cyc();
    cfg_valid = 1'b0;
    check("max_rate", rate_q, 10);
    check("max_err", cfg_err, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("max_tick_%0d", i), tick, 1);
    end
    check("max_cnt", frame_cnt, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
